univ_shift_register: RTL and testbench

Parametrised universal shift register; successor to the fixed 4-bit bidirectional shifter.
- Adds parallel load, clear, rotate and arithmetic-right modes.
- Adds multi-step shifts by a commanded amount, with a valid/ready command handshake, a busy flag and a done pulse.
- Sits between serial links and parallel datapaths as a generic serialiser, deserialiser and bit-manipulation unit.

---
 rtl/ushreg_pkg.sv | 31 +++
 rtl/univ_shift_register_if.sv | 30 +++
 rtl/ushreg_step.sv | 28 ++
 rtl/univ_shift_register.sv | 107 ++++++++++
 tb/tb_univ_shift_register.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/ushreg_pkg.sv
// rtl/ushreg_pkg.sv - op codes, FSM states and helpers for the universal shift register
package ushreg_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_ROL  = 3'd5;
  localparam logic [2:0] OP_ASR  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int amt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op >= OP_SHR) && (op <= OP_ASR);
  endfunction

  // Ops whose shifted-out bit leaves through the LSB and lands on so_r.
  function automatic logic exits_right(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_ROR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/univ_shift_register_if.sv
// rtl/univ_shift_register_if.sv - command, serial and status bundle of the universal shift register
interface univ_shift_register_if
  import ushreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = amt_width(WIDTH)
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [WIDTH-1:0] load_data;
  logic             serial_in_r;
  logic             serial_in_l;
  logic [WIDTH-1:0] q;
  logic             so_r;
  logic             so_l;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, load_data, serial_in_r, serial_in_l,
    input  cmd_ready, q, so_r, so_l, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, load_data, serial_in_r, serial_in_l,
    output cmd_ready, q, so_r, so_l, busy, done
  );
endinterface

// File: rtl/ushreg_step.sv
// rtl/ushreg_step.sv - combinational one-position shift/rotate for the universal shift register
module ushreg_step
  import ushreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  output logic [WIDTH-1:0] q_next,
  output logic             shift_out
);

  always_comb begin
    q_next    = q;
    shift_out = 1'b0;
    case (op)
      OP_SHR: begin q_next = {serial_in_r, q[WIDTH-1:1]}; shift_out = q[0];       end
      OP_SHL: begin q_next = {q[WIDTH-2:0], serial_in_l}; shift_out = q[WIDTH-1]; end
      OP_ROR: begin q_next = {q[0], q[WIDTH-1:1]};        shift_out = q[0];       end
      OP_ROL: begin q_next = {q[WIDTH-2:0], q[WIDTH-1]};  shift_out = q[WIDTH-1]; end
      OP_ASR: begin q_next = {q[WIDTH-1], q[WIDTH-1:1]};  shift_out = q[0];       end
      default: ;
    endcase
  end

endmodule

// File: rtl/univ_shift_register.sv
// rtl/univ_shift_register.sv - universal shift register with multi-step commands (optional abort: USHREG_ABORT_EN)
module univ_shift_register
  import ushreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = amt_width(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
`ifdef USHREG_ABORT_EN
  input  logic abort,
`endif
  univ_shift_register_if.slave bus
);

  state_t           state;
  logic [AMT_W-1:0] cnt;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] q_r;
  logic             so_r_r;
  logic             so_l_r;
  logic             done_r;
  logic             accept;
  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_q;
  logic             step_out;

  assign accept  = bus.cmd_valid && (state == ST_IDLE);
  // The first step happens on the accept edge, so the live op drives the shifter in IDLE.
  assign step_op = (state == ST_SHIFT) ? op_r : bus.cmd_op;

  ushreg_step #(.WIDTH(WIDTH)) u_step (
    .q           (q_r),
    .op          (step_op),
    .serial_in_r (bus.serial_in_r),
    .serial_in_l (bus.serial_in_l),
    .q_next      (step_q),
    .shift_out   (step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_r   <= OP_NOP;
      q_r    <= '0;
      so_r_r <= 1'b0;
      so_l_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_r <= bus.cmd_op;
            if (is_shift_op(bus.cmd_op)) begin
              if (bus.cmd_amt != '0) begin
                q_r <= step_q;
                if (exits_right(bus.cmd_op)) so_r_r <= step_out;
                else                         so_l_r <= step_out;
              end
              if (bus.cmd_amt > AMT_W'(1)) begin
                state <= ST_SHIFT;
                cnt   <= bus.cmd_amt - AMT_W'(1);
              end else begin
                done_r <= 1'b1;
              end
            end else begin
              if (bus.cmd_op == OP_LOAD)     q_r <= bus.load_data;
              else if (bus.cmd_op == OP_CLR) q_r <= '0;
              done_r <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
`ifdef USHREG_ABORT_EN
          if (abort) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done_r <= 1'b1;
          end else begin
`else
          begin
`endif
            q_r <= step_q;
            if (exits_right(op_r)) so_r_r <= step_out;
            else                   so_l_r <= step_out;
            if (cnt == AMT_W'(1)) begin
              state  <= ST_IDLE;
              done_r <= 1'b1;
            end
            cnt <= cnt - AMT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.q         = q_r;
  assign bus.so_r      = so_r_r;
  assign bus.so_l      = so_l_r;
  assign bus.busy      = (state == ST_SHIFT);
  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.done      = done_r;

endmodule

// File: tb/tb_univ_shift_register.sv
// tb/tb_univ_shift_register.sv - directed scoreboard bench for univ_shift_register at WIDTH=4
module tb_univ_shift_register;
  import ushreg_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef USHREG_ABORT_EN
  logic abort = 1'b0;
`endif
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] q;
    logic       so_r;
    logic       so_l;
  } exp_t;
  exp_t sb[$];

  univ_shift_register_if #(.WIDTH(4), .AMT_W(3)) bus ();

  univ_shift_register #(.WIDTH(4), .AMT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef USHREG_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] amt, input logic [3:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_amt   = amt;
    bus.load_data = data;
  endtask

  task automatic expect_final(input logic [3:0] q, input logic so_r, input logic so_l);
    exp_t e;
    e.q = q; e.so_r = so_r; e.so_l = so_l;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, bus.done, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_q"}, bus.q, e.q);
      chk({tag, "_so_r"}, bus.so_r, e.so_r);
      chk({tag, "_so_l"}, bus.so_l, e.so_l);
    end else begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_amt = '0;
    bus.load_data = '0; bus.serial_in_r = 1'b0; bus.serial_in_l = 1'b0;
    tick(); tick();
    chk("rst_q", bus.q, 0);
    chk("rst_so", {bus.so_r, bus.so_l}, 0);
    chk("rst_busy_done", {bus.busy, bus.done}, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    rst_n = 1'b1;
    tick();

    // 1: SHR by 3 with serial_in_r=1 fills from the top
    bus.serial_in_r = 1'b1;
    expect_final(4'b1110, 1'b0, 1'b0);
    drive(OP_SHR, 3'd3, 4'h0); tick(); bus.cmd_valid = 1'b0;
    chk("t1_q1", bus.q, 4'b1000); chk("t1_busy1", bus.busy, 1); chk("t1_ready1", bus.cmd_ready, 0);
    tick();
    chk("t1_q2", bus.q, 4'b1100); chk("t1_busy2", bus.busy, 1); chk("t1_nodone2", bus.done, 0);
    tick();
    chk("t1_busy3", bus.busy, 0);
    wait_done("t1");
    bus.serial_in_r = 1'b0;

    // 2: LOAD then ROL by WIDTH+1
    expect_final(4'b1011, 1'b0, 1'b0);
    drive(OP_LOAD, 3'd0, 4'b1011); tick();
    wait_done("t2_load");
    expect_final(4'b0111, 1'b0, 1'b1);
    drive(OP_ROL, 3'd5, 4'h0); tick(); bus.cmd_valid = 1'b0;
    chk("t2_q1", bus.q, 4'b0111);
    tick(); chk("t2_q2", bus.q, 4'b1110); chk("t2_sol2", bus.so_l, 0);
    tick(); chk("t2_q3", bus.q, 4'b1101);
    tick(); chk("t2_q4", bus.q, 4'b1011); chk("t2_busy4", bus.busy, 1);
    tick();
    wait_done("t2_rol");
    tick(); chk("t2_done_once", bus.done, 0);

    // 3: ASR keeps the sign bit
    expect_final(4'b1001, 1'b0, 1'b1);
    drive(OP_LOAD, 3'd0, 4'b1001); tick();
    wait_done("t3_load");
    expect_final(4'b1110, 1'b0, 1'b1);
    drive(OP_ASR, 3'd2, 4'h0); tick(); bus.cmd_valid = 1'b0;
    chk("t3_q1", bus.q, 4'b1100); chk("t3_sor1", bus.so_r, 1);
    tick();
    wait_done("t3_asr");

    // 4: command while busy is held off, then taken the cycle done is high
    bus.serial_in_l = 1'b0;
    expect_final(4'b0000, 1'b0, 1'b1);
    expect_final(4'b1111, 1'b0, 1'b1);
    drive(OP_SHL, 3'd3, 4'h0); tick();
    drive(OP_LOAD, 3'd0, 4'b1111);
    chk("t4_ready_busy", bus.cmd_ready, 0);
    tick(); chk("t4_ignored", bus.q, 4'b1000);
    tick();
    chk("t4_ready_done", bus.cmd_ready, 1);
    wait_done("t4_shl");
    tick(); bus.cmd_valid = 1'b0;
    wait_done("t4_load");

    // 5: zero-amount shift and NOP, then back-to-back loads
    expect_final(4'b1111, 1'b0, 1'b1);
    drive(OP_SHL, 3'd0, 4'h0); tick();
    chk("t5_nobusy_shl", bus.busy, 0);
    wait_done("t5_shl0");
    expect_final(4'b1111, 1'b0, 1'b1);
    drive(OP_NOP, 3'd0, 4'h0); tick();
    chk("t5_nobusy_nop", bus.busy, 0);
    wait_done("t5_nop");
    expect_final(4'b0101, 1'b0, 1'b1);
    drive(OP_LOAD, 3'd0, 4'b0101); tick();
    wait_done("t5_load_a");
    expect_final(4'b1010, 1'b0, 1'b1);
    drive(OP_LOAD, 3'd0, 4'b1010); tick(); bus.cmd_valid = 1'b0;
    wait_done("t5_load_b");

    // large amounts: ASR saturates, SHR flushes
    expect_final(4'b1000, 1'b0, 1'b1);
    drive(OP_LOAD, 3'd0, 4'b1000); tick();
    wait_done("sat_load");
    expect_final(4'b1111, 1'b1, 1'b1);
    drive(OP_ASR, 3'd7, 4'h0); tick(); bus.cmd_valid = 1'b0;
    wait_done("asr7");
    expect_final(4'b0000, 1'b0, 1'b1);
    drive(OP_SHR, 3'd6, 4'h0); tick(); bus.cmd_valid = 1'b0;
    wait_done("shr6");

    // 6: reset mid-shift abandons the command
    expect_final(4'b1010, 1'b0, 1'b1);
    drive(OP_LOAD, 3'd0, 4'b1010); tick();
    wait_done("t6_load");
    drive(OP_SHR, 3'd4, 4'h0); tick(); bus.cmd_valid = 1'b0;
    tick();
    chk("t6_q2", bus.q, 4'b0010);
    rst_n = 1'b0; #1;
    chk("t6_rst_q", bus.q, 0);
    chk("t6_rst_busy", bus.busy, 0);
    tick(); rst_n = 1'b1;
    tick(); chk("t6_nodone_a", bus.done, 0);
    tick(); chk("t6_nodone_b", bus.done, 0);

`ifdef USHREG_ABORT_EN
    expect_final(4'b1010, 1'b0, 1'b0);
    drive(OP_LOAD, 3'd0, 4'b1010); tick();
    wait_done("ab_load");
    expect_final(4'b0010, 1'b1, 1'b0);
    drive(OP_SHR, 3'd4, 4'h0); tick(); bus.cmd_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick(); abort = 1'b0;
    chk("ab_busy", bus.busy, 0);
    wait_done("ab_stop");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
